bcd_up_counter_chain: RTL
=========================

Name: bcd_up_counter_chain

Overview:
- Multi-digit synchronous BCD up counter: the counting-up counterpart of the team's BCD down counter.
- Cascades DIGITS decade stages with an internal ripple-carry enable chain, synchronous clear and parallel load with BCD validity checking.
- Gives wrap and terminal-count indications for chaining to further counter blocks or timers.
- Sits in the display/timebase path; its q bus drives seven-segment decoders directly.

Parameters:
- DIGITS, 4, number of BCD decades; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all digits.
- en  input  1  count enable; one increment per enabled cycle.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
- q  output  4*DIGITS  current count, BCD, digit 0 least significant.
- tc  output  1  combinational terminal count: en high and q at the wrap value.
- wrap  output  1  registered one-cycle pulse after the counter wraps to 0.
- load_err  output  1  registered one-cycle pulse after a load containing an invalid digit.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n low): q = 0, wrap = 0, load_err = 0, immediately and independent of clk.
- Priority per rising edge: clr > load > en > hold.
- clr: q <= 0; wrap <= 0; load_err <= 0.
- load: each digit d <= load_val digit if 0..9; digits 10..15 are forced to 0, and load_err <= 1 if any were. Otherwise load_err <= 0. wrap <= 0. en is ignored in a load cycle.
- en (no clr/load):
  - Digit 0 increments.
  - Digit k increments only when en is high and digits 0..k-1 are all 9.
  - A digit at 9 that increments becomes 0 and passes the carry up.
- Wrap value: all digits 9 (e.g. 9999 for DIGITS = 4). At the wrap value with en, q <= 0 and wrap <= 1 for exactly one cycle.
- wrap and load_err are 0 in every cycle where their set condition is not met; they are pulses, not sticky.
- tc = en & (q == wrap value). Purely combinational, no clk latency; used as the en of a cascaded next block.
- Latency: q reflects en/load/clr on the edge where they are sampled; no pipeline.
- Hold (en = 0, no clr/load): q unchanged, wrap <= 0, load_err <= 0.
- Invalid digits cannot appear in q: the reset, clr and load paths guarantee every digit stays in 0..9.
- Reset mid-count, including while wrap or load_err is high, clears all state asynchronously. The first count after rst_n rises produces 0001.
- All updates are nonblocking; digit increment arithmetic is 4 bits wide per digit, with no binary carry across digits.

Optional Feature:
- Macro: BCD_LIMIT_EN.
- Defined:
  - Adds input limit (4*DIGITS, BCD), and the wrap value becomes limit instead of all-9s. Counting at q == limit with en gives q <= 0, wrap pulse, and tc is asserted.
  - If q > limit (e.g. after a load), counting continues up to all-9s and wraps there.
  - An invalid digit in limit is treated as 9.
- Not defined: no limit port; wrap value is fixed at all-9s.

Test Plan:
- Reset then 12 enabled cycles, DIGITS=2 -> q = 12 (0x12), wrap never set, tc = 0 throughout.
- load 0x0998 (DIGITS=4), en for 2 cycles -> q 0999 then 1000; carry rippled into three digits on one edge.
- load 0x9999, en high -> tc = 1 before the edge; after the edge q = 0000, wrap = 1 for one cycle, then 0.
- load 0x12A4 -> q = 0x1204, load_err = 1 for one cycle. Same edge as en = 1 -> en ignored. clr and load together -> q = 0, load_err = 0.
- en held, rst_n pulsed low mid-cycle at q = 0x0057 -> q = 0 asynchronously; count resumes 0001 after release.
- BCD_LIMIT_EN defined, limit = 0x0059, count from 0x0058 -> 0059 (tc = 1) then 0000 with wrap. load 0x0070 -> counts to 9999 before wrapping.

Source files
------------

// File: rtl/bcd_up_counter_chain.sv
// Multi-digit synchronous BCD up counter with ripple-carry chain, clear and checked load.
// Optional BCD_LIMIT_EN adds a programmable wrap value on the limit input.
module bcd_up_counter_chain #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_LIMIT_EN
  input  logic [4*DIGITS-1:0]   limit,
`endif
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    r_q;
  logic            r_wrap;
  logic            r_err;

  logic [W-1:0]    w_inc;
  logic [W-1:0]    w_ld;
  logic [W-1:0]    w_lim;
  logic [DIGITS:0] w_cy;
  logic            w_bad;
  logic            w_at_wrap;

  always_comb begin
    logic [3:0] v_d;
    logic [3:0] v_l;
    logic [3:0] v_m;
    w_inc   = '0;
    w_ld    = '0;
    w_lim   = '0;
    w_cy    = '0;
    w_bad   = 1'b0;
    v_d     = '0;
    v_l     = '0;
    v_m     = '0;
    w_cy[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      v_d = r_q[4*k +: 4];
      // carry into digit k+1 only when all lower digits sit at 9
      w_cy[k+1] = w_cy[k] & (v_d == 4'd9);
      if (w_cy[k])
        w_inc[4*k +: 4] = (v_d == 4'd9) ? 4'd0 : v_d + 4'd1;
      else
        w_inc[4*k +: 4] = v_d;
      v_l = load_val[4*k +: 4];
      if (v_l > 4'd9) begin
        w_ld[4*k +: 4] = 4'd0;
        w_bad          = 1'b1;
      end else begin
        w_ld[4*k +: 4] = v_l;
      end
`ifdef BCD_LIMIT_EN
      v_m = limit[4*k +: 4];
      w_lim[4*k +: 4] = (v_m > 4'd9) ? 4'd9 : v_m;
`else
      v_m = 4'd9;
      w_lim[4*k +: 4] = v_m;
`endif
    end
    // all-9s always wraps, also covering q above a programmed limit
    w_at_wrap = w_cy[DIGITS] | (r_q == w_lim);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (clr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (load) begin
      r_q    <= w_ld;
      r_wrap <= 1'b0;
      r_err  <= w_bad;
    end else if (en) begin
      r_err <= 1'b0;
      if (w_at_wrap) begin
        r_q    <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_q    <= w_inc;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  assign q        = r_q;
  assign wrap     = r_wrap;
  assign load_err = r_err;
  assign tc       = en & w_at_wrap;

endmodule
